// File: rtl/nibble_bus_pkg.sv
// Shared nibble-bus definitions: cycle types, control codes and the bus_ctl decoder.
// Used by the CPU core and by the memory-side responder.
package nibble_bus_pkg;

    typedef enum logic [2:0] {
        CYC_FETCH0,
        CYC_FETCH1,
        CYC_FETCH2,
        CYC_LOAD,
        CYC_STORE,
        CYC_RSVD
    } cyc_t;

    localparam logic [3:0] CTL_LOAD   = 4'b0111;
    localparam logic [3:0] CTL_STORE  = 4'b0011;
    localparam int         DMEM_DEPTH = 16;

    // bus_ctl[3:2] is part of the fetch address, so only [1:0] selects the fetch nibble.
    function automatic cyc_t decode_ctl(input logic [3:0] ctl);
        cyc_t cyc;
        if (ctl[1:0] == 2'b00)      cyc = CYC_FETCH0;
        else if (ctl[1:0] == 2'b01) cyc = CYC_FETCH1;
        else if (ctl[1:0] == 2'b10) cyc = CYC_FETCH2;
        else if (ctl == CTL_LOAD)   cyc = CYC_LOAD;
        else if (ctl == CTL_STORE)  cyc = CYC_STORE;
        else                        cyc = CYC_RSVD;
        return cyc;
    endfunction

endpackage

// File: rtl/nibble_bus_checker.sv
// Bus protocol checker: tracks fetch0/1/2 ordering and address consistency,
// flags illegal cycles in a sticky proto_err.
//
// state   | meaning
// EXP_F0  | instruction start: only fetch0 is legal
// EXP_F1  | fetch1 of the latched instruction address expected
// EXP_F2  | fetch2 of the latched instruction address expected
// EXP_ANY | instruction complete: fetch0, load or store legal
module nibble_bus_checker
    import nibble_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_en,
    input  cyc_t       cyc,
    input  logic [9:0] fetch_addr,
    input  logic [3:0] addr_hi,
    input  logic       err_clr,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        EXP_F0,
        EXP_F1,
        EXP_F2,
        EXP_ANY
    } chk_state_t;

    chk_state_t state, state_next;
    logic [9:0] inst_addr;
    logic       latch_addr;
    logic       bad;
    logic       err_next;
    logic       addr_match;
    logic       ls_ok;

    assign addr_match = (fetch_addr == inst_addr);
    assign ls_ok      = ((cyc == CYC_LOAD) || (cyc == CYC_STORE)) && (addr_hi == 4'd0);

    always_comb begin
        state_next = state;
        latch_addr = 1'b0;
        bad        = 1'b0;
        if (run_en) begin
            case (state)
                EXP_F0: begin
                    if (cyc == CYC_FETCH0) begin
                        state_next = EXP_F1;
                        latch_addr = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                EXP_F1: begin
                    if (cyc == CYC_FETCH1 && addr_match) state_next = EXP_F2;
                    else                                 bad = 1'b1;
                end
                EXP_F2: begin
                    if (cyc == CYC_FETCH2 && addr_match) state_next = EXP_ANY;
                    else                                 bad = 1'b1;
                end
                EXP_ANY: begin
                    if (cyc == CYC_FETCH0) begin
                        state_next = EXP_F1;
                        latch_addr = 1'b1;
                    end else if (ls_ok) begin
                        state_next = EXP_F0;
                    end else begin
                        bad = 1'b1;
                    end
                end
                default: bad = 1'b1;
            endcase
            if (bad) state_next = EXP_F0;
        end else begin
            // Holding EXP_F0 while idle makes every run_en rise start at an instruction boundary.
            state_next = EXP_F0;
        end
        err_next = bad ? 1'b1 : (err_clr ? 1'b0 : proto_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EXP_F0;
            inst_addr <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            proto_err <= err_next;
            if (latch_addr) inst_addr <= fetch_addr;
        end
    end

endmodule

// File: rtl/nibble_mem_responder.sv
// Memory-side responder for the CPU nibble bus: program memory with nibble preload,
// 16-nibble data memory, combinational read path. NIBBLE_MEM_CHECK_EN adds the protocol checker.
module nibble_mem_responder
    import nibble_bus_pkg::*;
#(
    parameter int PROG_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_addr,
    input  logic [3:0] bus_ctl,
    input  logic [3:0] bus_wdata,
    output logic [3:0] bus_rdata,
    output logic       bus_rdata_oe,
    input  logic       run_en,
    input  logic       prog_start,
    input  logic       prog_valid,
    output logic       prog_ready,
    input  logic [3:0] prog_nibble,
    input  logic       err_clr,
    output logic       proto_err
);

    localparam int AW = $clog2(PROG_DEPTH);

    cyc_t          cyc;
    logic [9:0]    fetch_addr;
    logic [AW-1:0] fetch_idx;
    logic [11:0]   instr;
    logic [3:0]    rd_val;
    logic          serve;

    logic [11:0]   pmem [PROG_DEPTH];
    logic [3:0]    dmem [DMEM_DEPTH];

    logic [AW-1:0] ptr_idx, wr_idx;
    logic [1:0]    ptr_sel, wr_sel;
    logic          prog_accept;

    assign cyc        = decode_ctl(bus_ctl);
    assign fetch_addr = {bus_addr, bus_ctl[3:2]};
    assign fetch_idx  = fetch_addr[AW-1:0];
    assign instr      = pmem[fetch_idx];
    assign serve      = run_en && rst_n;

    always_comb begin
        rd_val = 4'd0;
        case (cyc)
            CYC_FETCH0: rd_val = instr[3:0];
            CYC_FETCH1: rd_val = instr[7:4];
            CYC_FETCH2: rd_val = instr[11:8];
            CYC_LOAD:   rd_val = dmem[bus_addr[3:0]];
            default:    rd_val = 4'd0;
        endcase
    end

    assign bus_rdata    = serve ? rd_val : 4'd0;
    assign bus_rdata_oe = serve && (cyc == CYC_FETCH0 || cyc == CYC_FETCH1 ||
                                    cyc == CYC_FETCH2 || cyc == CYC_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 4'd0;
        end else if (run_en && cyc == CYC_STORE) begin
            dmem[bus_addr[3:0]] <= bus_wdata;
        end
    end

    // Preload pointer kept as (instruction index, nibble select) so no divide by 3 is needed.
    assign prog_ready  = !run_en;
    assign prog_accept = prog_valid && prog_ready;
    assign wr_idx      = prog_start ? '0 : ptr_idx;
    assign wr_sel      = prog_start ? 2'd0 : ptr_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_idx <= '0;
            ptr_sel <= 2'd0;
        end else if (prog_accept) begin
            if (wr_sel == 2'd2) begin
                ptr_idx <= wr_idx + 1'b1;
                ptr_sel <= 2'd0;
            end else begin
                ptr_idx <= wr_idx;
                ptr_sel <= wr_sel + 2'd1;
            end
        end else if (prog_start) begin
            ptr_idx <= '0;
            ptr_sel <= 2'd0;
        end
    end

    // Program memory has no reset so a CPU reset does not wipe the loaded program.
    always_ff @(posedge clk) begin
        if (rst_n && prog_accept) begin
            case (wr_sel)
                2'd0:    pmem[wr_idx][3:0]  <= prog_nibble;
                2'd1:    pmem[wr_idx][7:4]  <= prog_nibble;
                2'd2:    pmem[wr_idx][11:8] <= prog_nibble;
                default: ;
            endcase
        end
    end

`ifdef NIBBLE_MEM_CHECK_EN
    nibble_bus_checker u_checker (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_en     (run_en),
        .cyc        (cyc),
        .fetch_addr (fetch_addr),
        .addr_hi    (bus_addr[7:4]),
        .err_clr    (err_clr),
        .proto_err  (proto_err)
    );
`else
    logic unused_sink;
    assign unused_sink = ^{err_clr, fetch_addr};
    assign proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_mem_responder.sv
// Scoreboard bench for nibble_mem_responder: randomized bus/preload traffic against a
// behavioural memory + protocol model; a negedge monitor pops and compares.
module tb_nibble_mem_responder;

    localparam int PD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus_addr = '0;
    logic [3:0] bus_ctl = '0;
    logic [3:0] bus_wdata = '0;
    logic [3:0] bus_rdata;
    logic       bus_rdata_oe;
    logic       run_en = 1'b0;
    logic       prog_start = 1'b0;
    logic       prog_valid = 1'b0;
    logic       prog_ready;
    logic [3:0] prog_nibble = '0;
    logic       err_clr = 1'b0;
    logic       proto_err;

    always #5 clk = ~clk;

    nibble_mem_responder #(.PROG_DEPTH(PD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_addr     (bus_addr),
        .bus_ctl      (bus_ctl),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_oe (bus_rdata_oe),
        .run_en       (run_en),
        .prog_start   (prog_start),
        .prog_valid   (prog_valid),
        .prog_ready   (prog_ready),
        .prog_nibble  (prog_nibble),
        .err_clr      (err_clr),
        .proto_err    (proto_err)
    );

    typedef struct packed {
        logic oe;
        logic err;
    } exp_t;

    exp_t       cyc_q[$];
    logic [3:0] rd_q[$];
    int         checks = 0;
    int         errors = 0;

    // Reference model state
    logic [11:0] m_pmem [PD];
    logic [3:0]  m_dmem [16];
    int          m_ptr = 0;
    int          m_need = 0;       // 0: instruction start, 1/2: that fetch nibble next, 3: anything legal
    logic [9:0]  m_iaddr = '0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_rdata_oe === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_oe: rdata %0h presented with no read expected at %0t", bus_rdata, $time);
            end else begin
                check("rdata", {28'd0, bus_rdata}, {28'd0, rd_q.pop_front()});
            end
        end else if (run_en === 1'b0 || bus_ctl == 4'b1011 || bus_ctl == 4'b1111) begin
            check("rdata_quiet", {28'd0, bus_rdata}, 32'd0);
        end
        check("prog_ready", {31'd0, prog_ready}, {31'd0, !run_en});
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("oe", {31'd0, bus_rdata_oe}, {31'd0, e.oe});
            check("proto_err", {31'd0, proto_err}, {31'd0, e.err});
        end
    end

    // One bus cycle with the inputs currently driven: push expectations, then apply the model at the edge.
    task automatic step();
        exp_t        e;
        logic [9:0]  a10;
        logic [11:0] w;
        logic        rd;
        logic        bad;
        int          p;
        int          n;
        logic        is_ls;
        a10  = {bus_addr, bus_ctl[3:2]};
        n    = int'(bus_ctl[1:0]);
        rd   = rst_n && run_en && (n != 3 || bus_ctl == 4'b0111);
        e.oe = rd;
`ifdef NIBBLE_MEM_CHECK_EN
        e.err = m_err;
`else
        e.err = 1'b0;
`endif
        cyc_q.push_back(e);
        if (rd) begin
            if (n != 3) begin
                w = m_pmem[int'(a10) % PD];
                rd_q.push_back(w[4*n +: 4]);
            end else begin
                rd_q.push_back(m_dmem[bus_addr[3:0]]);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_dmem[i] = 4'd0;
            m_ptr  = 0;
            m_need = 0;
            m_err  = 1'b0;
        end else begin
            if (!run_en && prog_valid) begin
                p = prog_start ? 0 : m_ptr;
                m_pmem[p/3][4*(p%3) +: 4] = prog_nibble;
                m_ptr = (p + 1) % (3 * PD);
            end else if (prog_start) begin
                m_ptr = 0;
            end
            if (run_en && bus_ctl == 4'b0011) m_dmem[bus_addr[3:0]] = bus_wdata;
            bad = 1'b0;
            if (run_en) begin
                is_ls = (bus_ctl == 4'b0111 || bus_ctl == 4'b0011);
                if (n == 0 && (m_need == 0 || m_need == 3)) begin
                    m_need  = 1;
                    m_iaddr = a10;
                end else if (n != 3 && n != 0 && m_need == n && a10 == m_iaddr) begin
                    m_need = n + 1;
                end else if (is_ls && m_need == 3 && bus_addr[7:4] == 4'd0) begin
                    m_need = 0;
                end else begin
                    bad    = 1'b1;
                    m_need = 0;
                end
            end else begin
                m_need = 0;
            end
            m_err = bad ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
        #1;
    endtask

    task automatic pre(input logic [3:0] nib, input logic start);
        prog_valid  = 1'b1;
        prog_nibble = nib;
        prog_start  = start;
        step();
        prog_valid = 1'b0;
        prog_start = 1'b0;
    endtask

    task automatic fetch(input logic [9:0] a, input logic [1:0] n);
        bus_addr = a[9:2];
        bus_ctl  = {a[1:0], n};
        step();
    endtask

    task automatic instr(input logic [9:0] a);
        fetch(a, 2'd0);
        fetch(a, 2'd1);
        fetch(a, 2'd2);
    endtask

    task automatic load(input logic [7:0] a);
        bus_addr = a;
        bus_ctl  = 4'b0111;
        step();
    endtask

    task automatic store(input logic [7:0] a, input logic [3:0] d);
        bus_addr  = a;
        bus_ctl   = 4'b0011;
        bus_wdata = d;
        step();
    endtask

    task automatic rsvd();
        bus_addr = 8'($urandom);
        bus_ctl  = ($urandom_range(0, 1) == 0) ? 4'b1011 : 4'b1111;
        step();
    endtask

    initial begin
        logic [9:0] a;
        logic [1:0] k;
        @(posedge clk);
        #1;
        // reset
        step();
        step();
        rst_n = 1'b1;
        // full fill plus one extra nibble that wraps onto pmem[0][3:0]
        for (int i = 0; i < 3 * PD; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            pre(4'($urandom), 1'b0);
        end
        pre(4'hC, 1'b0);
        // restart stream: reset mid-preload, then prog_start together with an accept
        pre(4'h9, 1'b0);
        pre(4'h9, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pre(4'h9, 1'b0);
        pre(4'h4, 1'b1);
        pre(4'h1, 1'b0);
        pre(4'h7, 1'b0);
        pre(4'h1, 1'b0);
        pre(4'h0, 1'b0);
        pre(4'h0, 1'b0);
        // run: basic fetches, wrapped addresses, store/load
        run_en = 1'b1;
        instr(10'd0);
        instr(10'd1);
        instr(10'(PD));
        instr(10'(PD + 1));
        store(8'h05, 4'hA);
        instr(10'd2);
        load(8'h05);
        // protocol errors and err_clr priority
        fetch(10'h10, 2'd0);
        fetch(10'h10, 2'd2);
        err_clr = 1'b1;
        fetch(10'h11, 2'd0);
        err_clr = 1'b0;
        fetch(10'h11, 2'd1);
        err_clr = 1'b1;
        load(8'h05);
        err_clr = 1'b0;
        instr(10'd3);
        load(8'h35);
        err_clr = 1'b1;
        instr(10'd4);
        err_clr = 1'b0;
        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            err_clr = ($urandom_range(0, 9) == 0);
            a = 10'($urandom);
            case ($urandom_range(0, 9))
                0: rsvd();
                1: begin
                    fetch(a, 2'd0);
                    k = 2'($urandom_range(1, 2));
                    fetch(($urandom_range(0, 1) == 0) ? a : 10'($urandom), k);
                end
                default: begin
                    instr(a);
                    if ($urandom_range(0, 1) == 0) begin
                        if ($urandom_range(0, 1) == 0)
                            store({($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0, 4'($urandom)}, 4'($urandom));
                        else
                            load({($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0, 4'($urandom)});
                    end
                end
            endcase
        end
        err_clr = 1'b0;
        // programming mode: stores ignored, read path quiet
        run_en = 1'b0;
        store(8'h05, 4'h3);
        load(8'h05);
        fetch(10'd0, 2'd0);
        run_en = 1'b1;
        instr(10'd0);
        load(8'h05);
        // reset clears dmem, keeps pmem
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        instr(10'd0);
        load(8'h05);
        instr(10'd1);
        run_en = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        checks++;
        if (rd_q.size() != 0 || cyc_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads and %0d cycles still pending, required 0", rd_q.size(), cyc_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
